rst_sequencer: RTL and testbench



---
 rtl/rst_sequencer.sv | 101 ++++++++++
 tb/tb_rst_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: async assert, sync release of NUM_OUTS domain resets
// in fixed order, with software restart and last-cause reporting.
module rst_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUTS    = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                arstn,
   input  logic                sw_rst_req,
   output logic [NUM_OUTS-1:0] rst_n_out,
   output logic                ready,
   output logic [1:0]          rst_cause
);

   localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ?
                         HOLD_CYCLES - 1 : GAP_CYCLES - 1;
   localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;
   localparam int IW   = $clog2(NUM_OUTS + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTS - 1);
   localparam logic [NUM_OUTS-1:0] ONE = NUM_OUTS'(1);

   typedef enum logic [1:0] {
      S_RESET,
      S_HOLD,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         sync      <= '0;
         state     <= S_RESET;
         cnt       <= '0;
         idx       <= '0;
         rst_n_out <= '0;
         ready     <= 1'b0;
         rst_cause <= 2'b01;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
         unique case (state)
            S_RESET: begin
               if (sync[SYNC_STAGES-1]) begin
                  state <= S_HOLD;
                  cnt   <= '0;
               end
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  rst_n_out <= rst_n_out | ONE;
                  cnt       <= '0;
                  idx       <= IW'(1);
                  if (NUM_OUTS == 1) begin
                     state <= S_RUN;
                     ready <= 1'b1;
                  end else begin
                     state <= S_RELEASE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RELEASE: begin
               if (cnt == GAP_LAST) begin
                  // shift form avoids an out-of-range bit select
                  rst_n_out <= rst_n_out | (ONE << idx);
                  cnt       <= '0;
                  idx       <= idx + IW'(1);
                  if (idx == IDX_LAST) begin
                     state <= S_RUN;
                     ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RUN: begin
               if (sw_rst_req) begin
                  rst_n_out <= '0;
                  ready     <= 1'b0;
                  rst_cause <= 2'b10;
                  state     <= S_HOLD;
                  cnt       <= '0;
                  idx       <= '0;
               end
            end
            default: state <= S_RESET;
         endcase
      end
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance plus a
// NUM_OUTS=1 / HOLD_CYCLES=1 corner instance.
module tb_rst_sequencer;

   logic       clk;
   logic       arstn;
   logic       sw_rst_req;
   logic [3:0] rst_n_out;
   logic       ready;
   logic [1:0] rst_cause;

   logic       arstn1;
   logic       sw_rst_req1;
   logic [0:0] rst_n_out1;
   logic       ready1;
   logic [1:0] rst_cause1;

   int total;
   int passed;
   int e;

   rst_sequencer dut (
      .clk        (clk),
      .arstn      (arstn),
      .sw_rst_req (sw_rst_req),
      .rst_n_out  (rst_n_out),
      .ready      (ready),
      .rst_cause  (rst_cause)
   );

   rst_sequencer #(
      .SYNC_STAGES (2),
      .NUM_OUTS    (1),
      .HOLD_CYCLES (1),
      .GAP_CYCLES  (4)
   ) dut1 (
      .clk        (clk),
      .arstn      (arstn1),
      .sw_rst_req (sw_rst_req1),
      .rst_n_out  (rst_n_out1),
      .ready      (ready1),
      .rst_cause  (rst_cause1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   // advance to 1 ns after edge k of the current sequence
   task automatic to_edge(input int k);
      repeat (k - e) @(posedge clk);
      #1;
      e = k;
   endtask

   initial begin
      total       = 0;
      passed      = 0;
      e           = 0;
      arstn       = 1'b0;
      arstn1      = 1'b0;
      sw_rst_req  = 1'b0;
      sw_rst_req1 = 1'b0;

      repeat (5) @(posedge clk);
      #1;
      check("reset_out", 32'(rst_n_out), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_cause", 32'(rst_cause), 32'h1);

      @(negedge clk);
      arstn  = 1'b1;
      arstn1 = 1'b1;
      e      = 0;

      // corner instance and power-on with ignored requests
      to_edge(3);
      check("corner_e3_out", 32'(rst_n_out1), 32'h0);
      check("corner_e3_ready", 32'(ready1), 32'h0);
      to_edge(4);
      check("corner_e4_out", 32'(rst_n_out1), 32'h1);
      check("corner_e4_ready", 32'(ready1), 32'h1);

      to_edge(9);
      sw_rst_req = 1'b1;
      to_edge(10);
      sw_rst_req = 1'b0;
      to_edge(18);
      check("po_e18", 32'(rst_n_out), 32'h0);
      to_edge(19);
      check("po_e19", 32'(rst_n_out), 32'h1);
      to_edge(20);
      sw_rst_req = 1'b1;
      to_edge(21);
      sw_rst_req = 1'b0;
      to_edge(22);
      check("po_e22", 32'(rst_n_out), 32'h1);
      to_edge(23);
      check("po_e23", 32'(rst_n_out), 32'h3);
      to_edge(26);
      check("po_e26", 32'(rst_n_out), 32'h3);
      to_edge(27);
      check("po_e27", 32'(rst_n_out), 32'h7);
      to_edge(30);
      check("po_e30_out", 32'(rst_n_out), 32'h7);
      check("po_e30_ready", 32'(ready), 32'h0);
      to_edge(31);
      check("po_e31_out", 32'(rst_n_out), 32'hf);
      check("po_e31_ready", 32'(ready), 32'h1);
      check("po_cause", 32'(rst_cause), 32'h1);
      to_edge(40);
      check("po_e40_out", 32'(rst_n_out), 32'hf);
      check("po_e40_ready", 32'(ready), 32'h1);

      // software reset sampled at R = E41
      sw_rst_req = 1'b1;
      to_edge(41);
      sw_rst_req = 1'b0;
      check("sw_r_out", 32'(rst_n_out), 32'h0);
      check("sw_r_ready", 32'(ready), 32'h0);
      check("sw_r_cause", 32'(rst_cause), 32'h2);
      to_edge(56);
      check("sw_r15", 32'(rst_n_out), 32'h0);
      to_edge(57);
      check("sw_r16", 32'(rst_n_out), 32'h1);
      to_edge(60);
      check("sw_r19", 32'(rst_n_out), 32'h1);
      to_edge(61);
      check("sw_r20", 32'(rst_n_out), 32'h3);
      to_edge(65);
      check("sw_r24", 32'(rst_n_out), 32'h7);
      to_edge(68);
      check("sw_r27_ready", 32'(ready), 32'h0);
      to_edge(69);
      check("sw_r28_out", 32'(rst_n_out), 32'hf);
      check("sw_r28_ready", 32'(ready), 32'h1);
      check("sw_r28_cause", 32'(rst_cause), 32'h2);
      check("corner_still_run", 32'(ready1), 32'h1);

      // asynchronous assertion restores arstn cause
      arstn = 1'b0;
      #1;
      check("arst_out", 32'(rst_n_out), 32'h0);
      check("arst_ready", 32'(ready), 32'h0);
      check("arst_cause", 32'(rst_cause), 32'h1);
      @(negedge clk);
      arstn = 1'b1;
      e     = 0;

      // mid-sequence abort between E24 and E25
      to_edge(24);
      check("ab_e24", 32'(rst_n_out), 32'h3);
      #2;
      arstn = 1'b0;
      #1;
      check("ab_low_out", 32'(rst_n_out), 32'h0);
      check("ab_low_ready", 32'(ready), 32'h0);
      #2;
      arstn = 1'b1;
      e     = 0;
      to_edge(18);
      check("ab_e18", 32'(rst_n_out), 32'h0);
      to_edge(19);
      check("ab_e19", 32'(rst_n_out), 32'h1);
      to_edge(23);
      check("ab_e23", 32'(rst_n_out), 32'h3);
      to_edge(27);
      check("ab_e27", 32'(rst_n_out), 32'h7);
      to_edge(30);
      check("ab_e30_ready", 32'(ready), 32'h0);
      to_edge(31);
      check("ab_e31_out", 32'(rst_n_out), 32'hf);
      check("ab_e31_ready", 32'(ready), 32'h1);

      // continuous request: restart only on each RUN entry
      sw_rst_req = 1'b1;
      to_edge(32);
      check("cont_e32_ready", 32'(ready), 32'h0);
      check("cont_e32_cause", 32'(rst_cause), 32'h2);
      to_edge(59);
      check("cont_e59_ready", 32'(ready), 32'h0);
      to_edge(60);
      check("cont_e60_ready", 32'(ready), 32'h1);
      check("cont_e60_out", 32'(rst_n_out), 32'hf);
      to_edge(61);
      check("cont_e61_ready", 32'(ready), 32'h0);
      check("cont_e61_out", 32'(rst_n_out), 32'h0);
      to_edge(88);
      check("cont_e88_ready", 32'(ready), 32'h0);
      to_edge(89);
      check("cont_e89_ready", 32'(ready), 32'h1);
      to_edge(90);
      check("cont_e90_ready", 32'(ready), 32'h0);
      sw_rst_req = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
